// File: rtl/mdu_iterative_if.sv
// Request/response bundle between the EX stage and the iterative multiply/divide unit.
interface mdu_iterative_if #(
  parameter int DATA_WIDTH = 32
);
  logic                      start;
  logic [1:0]                op;
  logic [DATA_WIDTH-1:0]     operand_1;
  logic [DATA_WIDTH-1:0]     operand_2;
  logic                      cancel;
  logic                      busy;
  logic                      done;
  logic [2*DATA_WIDTH-1:0]   result;

  modport master (
    output start, op, operand_1, operand_2, cancel,
    input  busy, done, result
  );

  modport slave (
    input  start, op, operand_1, operand_2, cancel,
    output busy, done, result
  );
endinterface

// File: rtl/mdu_iterative.sv
// Multi-cycle multiply/divide unit for the EX stage HI/LO path.
// op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. result = {HI, LO}.
// Multiply is held for MUL_CYCLES edges; divide is restoring radix-2 with a
// final sign fix-up cycle. Divide by zero gives LO=all ones, HI=dividend.
// Optional macro MDU_EARLY_OUT_EN: divides with |dividend| < |divisor|
// finish after one edge with LO=0, HI=dividend.
module mdu_iterative #(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  mdu_iterative_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam int MW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            msgn_q, msgn_d;
  logic [W-1:0]    dmag_q, dmag_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    quot_q, quot_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            dz_q, dz_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [MW-1:0]   mcnt_q, mcnt_d;
  logic [2*W-1:0]  result_q, result_d;

  logic            sgn_in, a_neg_in, b_neg_in, dz_in;
  logic [W-1:0]    amag_in, bmag_in;
  logic [2*W-1:0]  ext_a, ext_b, prod;
  logic [W:0]      shifted, diff;
  logic [W-1:0]    q_fix, r_fix;

  // Operand preparation, product, one restoring step and the sign fix-up.
  always_comb begin
    sgn_in   = ~bus.op[0];
    a_neg_in = sgn_in & bus.operand_1[W-1];
    b_neg_in = sgn_in & bus.operand_2[W-1];
    amag_in  = a_neg_in ? -bus.operand_1 : bus.operand_1;
    bmag_in  = b_neg_in ? -bus.operand_2 : bus.operand_2;
    dz_in    = (bus.operand_2 == '0);

    ext_a = {{W{msgn_q & a_q[W-1]}}, a_q};
    ext_b = {{W{msgn_q & b_q[W-1]}}, b_q};
    prod  = ext_a * ext_b;

    // Remainder is kept one bit wider during the trial subtract so the shifted
    // value never overflows for large unsigned divisors.
    shifted = {rem_q, quot_q[W-1]};
    diff    = shifted - {1'b0, dmag_q};

    q_fix = qneg_q ? -quot_q : quot_q;
    r_fix = rneg_q ? -rem_q  : rem_q;
  end

  // Next-state and datapath updates; cancel overrides everything else.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    msgn_d   = msgn_q;
    dmag_d   = dmag_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    cnt_d    = cnt_q;
    mcnt_d   = mcnt_q;
    result_d = result_q;

    if (bus.cancel) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            a_d    = bus.operand_1;
            b_d    = bus.operand_2;
            msgn_d = sgn_in;
            if (!bus.op[1]) begin
              state_d = S_MUL;
              mcnt_d  = MW'(MUL_CYCLES - 1);
            end else begin
              state_d = S_DIV;
              dmag_d  = bmag_in;
              qneg_d  = a_neg_in ^ b_neg_in;
              rneg_d  = a_neg_in;
              dz_d    = dz_in;
              rem_d   = '0;
              quot_d  = amag_in;
              cnt_d   = dz_in ? '0 : CW'(W);
`ifdef MDU_EARLY_OUT_EN
              // Quotient is zero: load the remainder directly and skip the loop.
              if (!dz_in && (amag_in < bmag_in)) begin
                cnt_d  = '0;
                rem_d  = amag_in;
                quot_d = '0;
              end
`endif
            end
          end
        end
        S_MUL: begin
          if (mcnt_q == '0) begin
            result_d = prod;
            state_d  = S_DONE;
          end else begin
            mcnt_d = mcnt_q - 1'b1;
          end
        end
        S_DIV: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            if (!diff[W]) begin
              rem_d  = diff[W-1:0];
              quot_d = {quot_q[W-2:0], 1'b1};
            end else begin
              rem_d  = shifted[W-1:0];
              quot_d = {quot_q[W-2:0], 1'b0};
            end
          end else begin
            result_d = dz_q ? {a_q, {W{1'b1}}} : {r_fix, q_fix};
            state_d  = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q      <= '0;
      b_q      <= '0;
      msgn_q   <= 1'b0;
      dmag_q   <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      cnt_q    <= '0;
      mcnt_q   <= '0;
      result_q <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      msgn_q   <= msgn_d;
      dmag_q   <= dmag_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      cnt_q    <= cnt_d;
      mcnt_q   <= mcnt_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q == S_MUL) || (state_q == S_DIV);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;
endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed vector table, hand-written
// multi-cycle sequences (ignored start, cancel, async reset) and random ops
// against a plain-arithmetic reference model.
module tb_mdu_iterative;
  localparam int W   = 32;
  localparam int MCY = 2;
`ifdef MDU_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = W + 1;
`endif

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mdu_iterative_if #(.DATA_WIDTH(W)) bus ();

  mdu_iterative #(.DATA_WIDTH(W), .MUL_CYCLES(MCY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     q, r;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    case (op)
      2'b00: q = sa * sb;
      2'b01: q = ua * ub;
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = ua / ub;
        r = ua % ub;
        return {r[31:0], q[31:0]};
      end
    endcase
    return q;
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ma, mb;
    if (op[1] == 1'b0) return MCY;
    if (b == 0) return 1;
    if (op == 2'b10) begin
      ma = $signed(a);
      mb = $signed(b);
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
    end else begin
      ma = longint'(a);
      mb = longint'(b);
    end
`ifdef MDU_EARLY_OUT_EN
    if (ma < mb) return 1;
`endif
    return W + 1;
  endfunction

  // Accept edge happens inside; returns #1 after it.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start     = 1'b1;
    bus.op        = op;
    bus.operand_1 = a;
    bus.operand_2 = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts edges until done rises, with a bounded budget.
  task automatic wait_done(output int n, output bit busy_ok);
    n = 0;
    busy_ok = 1'b1;
    while (n < 100) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      n++;
      #1;
      if (bus.done === 1'b1) break;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int lat);
    int n;
    bit bok;
    issue(op, a, b);
    check({name, "_done_drop"}, 64'(bus.done), 64'(0));
    wait_done(n, bok);
    check({name, "_latency"}, 64'(n), 64'(lat));
    check({name, "_result"}, bus.result, exp);
    check({name, "_busy"}, 64'(bok), 64'(1));
    check({name, "_busy_done"}, 64'(bus.busy), 64'(0));
  endtask

  initial begin
    int          n;
    bit          bok;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          sel;

    total = 0;
    bad   = 0;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.operand_1 = '0;
    bus.operand_2 = '0;
    bus.cancel = 1'b0;

    vecs[0]  = '{2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA, MCY};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, MCY};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, W + 1};
    vecs[3]  = '{2'b11, 32'h1234_5678, 32'h0000_0000, 64'h1234_5678_FFFF_FFFF, 1};
    vecs[4]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, W + 1};
    vecs[5]  = '{2'b01, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, MCY};
    vecs[6]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, W + 1};
    vecs[7]  = '{2'b10, 32'h8000_0000, 32'h0000_0000, 64'h8000_0000_FFFF_FFFF, 1};
    vecs[8]  = '{2'b11, 32'h0000_0003, 32'h0000_000A, 64'h0000_0003_0000_0000, EARLY_LAT};
    vecs[9]  = '{2'b10, 32'hFFFF_FFFD, 32'h0000_000A, 64'hFFFF_FFFD_0000_0000, EARLY_LAT};
    vecs[10] = '{2'b11, 32'h0000_0064, 32'h0000_0007, 64'h0000_0002_0000_000E, W + 1};

    // Asynchronous reset at start.
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_result", bus.result, 64'(0));
    #9 rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed table, run back to back so each restart happens from DONE.
    for (int i = 0; i < 11; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Result and done hold in DONE.
    repeat (3) @(posedge clk);
    #1;
    check("hold_done", 64'(bus.done), 64'(1));
    check("hold_result", bus.result, 64'h0000_0002_0000_000E);

    // Start while busy is ignored.
    issue(2'b11, 32'd200, 32'd9);
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op = 2'b00;
    bus.operand_1 = 32'd3;
    bus.operand_2 = 32'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(n, bok);
    check("ignore_latency", 64'(n + 5), 64'(W + 1));
    check("ignore_result", bus.result, 64'h0000_0002_0000_0016);

    // Cancel mid-divide with simultaneous start.
    issue(2'b11, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    bus.cancel = 1'b1;
    bus.start = 1'b1;
    bus.op = 2'b01;
    @(posedge clk);
    #1;
    bus.cancel = 1'b0;
    bus.start = 1'b0;
    check("cancel_done", 64'(bus.done), 64'(0));
    check("cancel_busy", 64'(bus.busy), 64'(0));
    check("cancel_result", bus.result, 64'h0000_0002_0000_0016);
    @(posedge clk);
    #1;
    check("cancel_idle", 64'(bus.busy), 64'(0));

    // Asynchronous reset in the middle of a multiply.
    issue(2'b00, 32'd3, 32'd5);
    check("mul_busy", 64'(bus.busy), 64'(1));
    #2 rst = 1'b0;
    #1;
    check("arst_busy", 64'(bus.busy), 64'(0));
    check("arst_done", 64'(bus.done), 64'(0));
    check("arst_result", bus.result, 64'(0));
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    check("arst_stay_idle", 64'(bus.done), 64'(0));
    run_op("post_rst", 2'b01, 32'd6, 32'd7, 64'd42, MCY);

    // Random operations against the reference model.
    for (int i = 0; i < 300; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = '0;
      else if (sel == 1) begin ra = $urandom_range(0, 50); rb = $urandom_range(1, 60); end
      else if (sel == 2) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 3) rb = $urandom_range(1, 20);
      issue(rop, ra, rb);
      wait_done(n, bok);
      check($sformatf("rnd%0d_lat", i), 64'(n), 64'(ref_lat(rop, ra, rb)));
      check($sformatf("rnd%0d_res", i), bus.result, ref_res(rop, ra, rb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
